// File: rtl/obi_slow_mem.sv
// obi_slow_mem: OBI slave memory with a programmable grant delay, a fixed
// response delay and a cap on outstanding transactions.
//
// Ports
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   req_i     OBI request
//   we_i      write enable (1 = write)
//   be_i      byte enables
//   addr_i    byte address (word index taken from addr_i[AW+1:2])
//   wdata_i   write data
//   gnt_o     OBI grant (combinational)
//   rvalid_o  response valid (registered)
//   rdata_o   read data (registered, 0 when rvalid_o=0)
module obi_slow_mem #(
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned GNT_LATENCY     = 2,
  parameter int unsigned RVALID_LATENCY  = 3,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned CW = (GNT_LATENCY > 0) ? $clog2(GNT_LATENCY + 1) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned L  = RVALID_LATENCY;

  logic [CW-1:0]        r_cnt;
  logic [OW-1:0]        r_outst;
  logic [L-1:0]         r_vld_pipe;
  logic [L-1:0][31:0]   r_dat_pipe;
  logic [31:0]          r_mem [NUM_WORDS];

  logic [AW-1:0]        w_idx;
  logic                 w_retire;
  logic                 w_accept;

  assign w_idx    = addr_i[AW+1:2];
  assign w_retire = r_vld_pipe[L-1];

  // A response leaving the pipeline this cycle frees its slot for a grant
  // in the same cycle, so streaming at the outstanding limit does not stall.
  assign gnt_o    = req_i && (r_cnt == CW'(GNT_LATENCY)) &&
                    ((32'(r_outst) - 32'(w_retire)) < 32'(MAX_OUTSTANDING));
  assign w_accept = req_i && gnt_o;

  assign rvalid_o = r_vld_pipe[L-1];
  assign rdata_o  = r_dat_pipe[L-1];

  // Grant wait counter: counts cycles of an ungranted request; a dropped
  // request or a grant restarts it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (!req_i || gnt_o) begin
      r_cnt <= '0;
    end else if (r_cnt < CW'(GNT_LATENCY)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outst <= '0;
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Response pipeline. Read data is captured at the grant edge; non-read
  // slots carry 0 so rdata_o is 0 whenever rvalid_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_accept;
      r_dat_pipe[0] <= (w_accept && !we_i) ? r_mem[w_idx] : 32'h0;
      for (int i = 1; i < L; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_dat_pipe[i] <= r_dat_pipe[i-1];
      end
    end
  end

  // Storage is deliberately not reset: granted writes survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (w_accept && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_words
    $error("obi_slow_mem: NUM_WORDS must be a power of two >= 2");
  end
  if (RVALID_LATENCY < 1) begin : g_bad_rlat
    $error("obi_slow_mem: RVALID_LATENCY must be >= 1");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RVALID_LATENCY) begin : g_bad_outst
    $error("obi_slow_mem: MAX_OUTSTANDING must be in 1..RVALID_LATENCY");
  end
  if (GNT_LATENCY > 65535) begin : g_bad_glat
    $error("obi_slow_mem: GNT_LATENCY out of range");
  end

`ifndef SYNTHESIS
  // Request attributes must stay stable while a request waits for its grant.
  logic        r_waiting;
  logic [68:0] r_held;
  logic [68:0] w_req_attr;
  assign w_req_attr = {addr_i, we_i, be_i, wdata_i};

  always_ff @(posedge clk_i) begin
    r_waiting <= req_i && !gnt_o;
    r_held    <= w_req_attr;
    if (r_waiting && req_i && (w_req_attr != r_held))
      $warning("obi_slow_mem: request attributes changed before grant");
  end
`endif

endmodule

// File: tb/tb_obi_slow_mem.sv
module tb_obi_slow_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req    [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Default parameters.
  obi_slow_mem u_def (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0])
  );

  // Same-cycle grant for the streaming case.
  obi_slow_mem #(.GNT_LATENCY(0), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2)) u_fast (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One full transaction. Cycle 0 is the cycle req rises; inputs change #1
  // after posedge, outputs are sampled at negedge.
  task automatic txn_chk(input int s, input bit w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input int exp_g, input string tag);
    int gc, rc;
    logic [31:0] rd;
    gc = -1; rc = -1; rd = 32'hxxxxxxxx;
    req[s] = 1'b1; we[s] = w; be[s] = b; addr[s] = a; wdata[s] = d;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt[s]) begin gc = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req[s] = 1'b0; we[s] = 1'b0;
    for (int c = gc + 1; c < gc + 20; c++) begin
      @(negedge clk);
      if (rvalid[s]) begin rc = c; rd = rdata[s]; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_gnt_cyc"}, 32'(gc), 32'(exp_g));
    chk({tag, "_rsp_lat"}, 32'(rc - gc), 32'd3);
    chk({tag, "_rdata"}, rd, exp_rd);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, rvalid[s]}, 32'd0);
    chk({tag, "_rdata_idle"}, rdata[s], 32'd0);
    @(posedge clk); #1;
  endtask

  int          sg [6];
  int          sr [6];
  logic [31:0] sd [6];
  int          ng, nr, k;
  bit          gave, seen;
  int          exp_g [6] = '{0, 1, 3, 4, 6, 7};
  int          exp_r [6] = '{3, 4, 6, 7, 9, 10};

  initial begin
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; be[s] = 4'h0; addr[s] = '0; wdata[s] = '0;
    end

    // Reset state
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_gnt", {31'b0, gnt[s]}, 32'd0);
      chk("rst_rvalid", {31'b0, rvalid[s]}, 32'd0);
      chk("rst_rdata", rdata[s], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic write then read
    txn_chk(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 2, "wr_10");
    txn_chk(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 2, "rd_10");

    // Byte-enable merge
    txn_chk(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 2, "wr_20a");
    txn_chk(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 32'h0, 2, "wr_20b");
    txn_chk(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 2, "rd_20");

    // Aliasing modulo NUM_WORDS, low address bits ignored
    txn_chk(0, 1'b1, 4'hF, 32'h0, 32'hCAFE0001, 32'h0, 2, "wr_0");
    txn_chk(0, 1'b0, 4'hF, 32'h1000, 32'h0, 32'hCAFE0001, 2, "rd_1000");
    txn_chk(0, 1'b0, 4'hF, 32'h1003, 32'h0, 32'hCAFE0001, 2, "rd_1003");

    // Request withdrawn before grant; counter restarts on re-raise
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10;
    @(negedge clk);
    chk("wd_gnt_c0", {31'b0, gnt[0]}, 32'd0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("wd_gnt_c1", {31'b0, gnt[0]}, 32'd0);
    @(posedge clk); #1;
    txn_chk(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 2, "wd_rd");

    // Streaming on the zero-grant-latency instance
    for (int i = 0; i < 6; i++)
      txn_chk(1, 1'b1, 4'hF, 32'(i * 4), 32'hA0000000 + 32'(i), 32'h0, 0, "fw");
    for (int i = 0; i < 6; i++) begin sg[i] = -1; sr[i] = -1; sd[i] = '0; end
    ng = 0; nr = 0; k = 0;
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      gave = gnt[1];
      if (gave && ng < 6) begin sg[ng] = c; ng++; end
      if (rvalid[1] && nr < 6) begin sr[nr] = c; sd[nr] = rdata[1]; nr++; end
      @(posedge clk); #1;
      if (gave) begin
        k++;
        if (k >= 6) req[1] = 1'b0;
        else addr[1] = 32'(k * 4);
      end
      if (nr == 6) break;
    end
    req[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stream_gnt_cyc", 32'(sg[i]), 32'(exp_g[i]));
      chk("stream_rsp_cyc", 32'(sr[i]), 32'(exp_r[i]));
      chk("stream_rdata", sd[i], 32'hA0000000 + 32'(i));
    end

    // Reset with two reads in flight
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
    @(negedge clk);
    chk("mr_gnt0", {31'b0, gnt[1]}, 32'd1);
    @(posedge clk); #1;
    addr[1] = 32'h4;
    @(negedge clk);
    chk("mr_gnt1", {31'b0, gnt[1]}, 32'd1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("mr_rst_gnt", {31'b0, gnt[s]}, 32'd0);
      chk("mr_rst_rvalid", {31'b0, rvalid[s]}, 32'd0);
      chk("mr_rst_rdata", rdata[s], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rvalid[0] || rvalid[1]) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mr_no_rvalid", {31'b0, seen}, 32'd0);
    txn_chk(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 2, "mr_rd_def");
    txn_chk(1, 1'b0, 4'hF, 32'h4, 32'h0, 32'hA0000001, 0, "mr_rd_fast");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obi_slow_mem.md
Name: obi_slow_mem

Overview:
- Parametrizable-latency OBI slave memory on the testbench external bus, attached to the SLOW_MEMORY_IDX port of the external crossbar.
- Replaces the tied-off slow RAM response so software can exercise long grant and response latencies on the external system bus.
- Word-addressed single-port storage with a fixed grant delay, a fixed response delay and a bounded number of outstanding transactions.

Parameters:
- NUM_WORDS, 1024: storage depth in 32-bit words; power of two, at least 2.
- GNT_LATENCY, 2: cycles req_i must be held high before gnt_o may assert; 0 allows a same-cycle grant.
- RVALID_LATENCY, 3: cycles from the grant cycle to the rvalid_o cycle; must be at least 1.
- MAX_OUTSTANDING, 2: maximum granted-but-unresponded transactions; range 1 to RVALID_LATENCY.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  OBI request.
- we_i  in  1  write enable (1 = write).
- be_i  in  4  byte enables.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- gnt_o  out  1  OBI grant.
- rvalid_o  out  1  OBI response valid.
- rdata_o  out  32  read data.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, wait counter=0, response pipeline empty, outstanding=0. Memory contents are not reset.
- Word index: addr_i[2+log2(NUM_WORDS)-1:2]. Upper bits are ignored, so addresses alias modulo NUM_WORDS. addr_i[1:0] is ignored.
- Grant counter (width clog2(GNT_LATENCY+1)):
  - Increments each cycle req_i=1 and gnt_o=0, saturating at GNT_LATENCY.
  - Clears on a grant or when req_i=0.
  - A request withdrawn before grant leaves no side effect.
- gnt_o is combinational and asserts when all of the following hold:
  - req_i=1;
  - counter==GNT_LATENCY;
  - (outstanding - retiring) < MAX_OUTSTANDING, where retiring=1 when the pipeline head produces rvalid_o this cycle.
- Full-rate streaming: with GNT_LATENCY=0, one grant per cycle is sustained while MAX_OUTSTANDING permits.
- Accept on the req_i&gnt_o edge:
  - Write: for each b with be_i[b]=1, mem[idx][8b+7:8b] <= wdata_i[8b+7:8b]; the other bytes are unchanged. Response data is 0.
  - Read: mem[idx] is sampled at the grant edge. A write granted in an earlier cycle is therefore visible to a read granted later.
- Response pipeline: RVALID_LATENCY stages of {valid, data} shift register.
  - A transaction granted in cycle T produces rvalid_o=1 with its rdata_o in cycle T+RVALID_LATENCY, in order, for exactly one cycle.
  - rvalid_o and rdata_o are registered outputs. rdata_o is 0 whenever rvalid_o=0.
- Outstanding counter: +1 on grant, -1 on rvalid_o; both in the same cycle leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- No ready/back-pressure on responses: the OBI master always accepts rvalid.
- Reset mid-operation: in-flight responses are dropped, no rvalid_o follows, and the counters clear. Writes already granted persist in memory.
- Simultaneous grant and retire at the limit: the grant is allowed by the retire term above.
- Assertions (simulation only):
  - GNT_LATENCY, RVALID_LATENCY and MAX_OUTSTANDING parameter ranges are checked at elaboration.
  - Warning if addr_i, we_i, be_i or wdata_i change while req_i=1 and gnt_o=0.

Test Plan:
- Default params. Write 0xDEADBEEF to addr 0x10 (be=0xF), then read 0x10.
  - Each gnt_o arrives 2 cycles after req_i rises.
  - Each rvalid_o arrives 3 cycles after its grant.
  - The read returns 0xDEADBEEF; the write response has rdata_o=0.
- Write 0x11223344 (be=0xF), then 0xAABBCCDD with be=0b0101 to the same word.
  - A read returns 0x11BB33DD.
- GNT_LATENCY=0, MAX_OUTSTANDING=2, RVALID_LATENCY=3, six back-to-back reads held continuously.
  - Grants in cycles 0,1,3,4,6,7; responses in cycles 3,4,6,7,9,10; data in order.
- Raise req_i for 1 cycle, drop it, raise again 2 cycles later.
  - No grant during the first attempt; the counter restarts; the grant comes 2 cycles after the re-raise.
- NUM_WORDS=1024. Write 0xCAFE0001 to addr 0x0, read addr 0x1000.
  - Returns 0xCAFE0001 (aliasing).
- Two reads granted, then rst_ni pulled low for 1 cycle before their rvalid.
  - No rvalid_o ever appears; outputs are 0 during reset; the next read after reset completes normally with the default latencies.
